// File: rtl/nbody_pkg.sv
// Shared constants, pair tag payload and sequencer state for the n-body pair issue path.
package nbody_pkg;

   localparam int unsigned BODIES          = 512;
   localparam int unsigned BODY_ADDR_WIDTH = $clog2(BODIES);

   // Arithmetic unit latencies shared with getAccl
   localparam int unsigned MultTime     = 7;
   localparam int unsigned AddTime      = 12;
   localparam int unsigned InvSqrtTime  = 59;
   localparam int unsigned ACCL_LATENCY = 3 * AddTime + 4 * MultTime + InvSqrtTime;

   localparam int unsigned RAM_LATENCY = 1;
   localparam int unsigned TAG_DELAY   = RAM_LATENCY + ACCL_LATENCY;
   localparam int unsigned DRAIN_W     = $clog2(TAG_DELAY);

   typedef struct packed {
      logic                       valid;
      logic [BODY_ADDR_WIDTH-1:0] i;
      logic [BODY_ADDR_WIDTH-1:0] j;
      logic                       self;
      logic                       last_j;
      logic                       last;
   } pair_tag_t;

   localparam int unsigned TAG_W = $bits(pair_tag_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FINISH
   } seq_state_t;

endpackage

// File: rtl/nbody_pair_sequencer_tag_delay_line.sv
// Fixed-depth shift register carrying pair tags alongside the RAM + getAccl latency.
module tag_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   // Shift one stage per cycle; flush empties every stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) sr[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < int'(DEPTH); k++) sr[k] <= '0;
      end else begin
         sr[0] <= din;
         for (int k = 1; k < int'(DEPTH); k++) sr[k] <= sr[k-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/nbody_pair_sequencer.sv
// Walks all (i, j) body pairs once per timestep and tags each pair through to the getAccl output.
// Optional feature: define NBODY_PAIR_SKIP_SELF_EN to never issue the i == j pairs.
module nbody_pair_sequencer
   import nbody_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
   output logic [BODY_ADDR_WIDTH-1:0] rd_i,
   output logic [BODY_ADDR_WIDTH-1:0] rd_j,
   output logic                       issue_valid,
   output logic                       res_valid,
   output logic [BODY_ADDR_WIDTH-1:0] res_i,
   output logic [BODY_ADDR_WIDTH-1:0] res_j,
   output logic                       res_self,
   output logic                       res_last_j,
   output logic                       res_last,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned AW = BODY_ADDR_WIDTH;

   seq_state_t         state;
   logic [AW:0]        n_q;
   logic [DRAIN_W-1:0] drain_cnt;

   logic [AW:0]        n_clamp_c;
   logic               pair_zero_c;
   logic [AW-1:0]      first_j_c;
   logic [AW-1:0]      n_m1_c;
   logic               row_last_c;
   logic               last_c;
   logic               self_c;
   pair_tag_t          tag_in_c;
   pair_tag_t          res_tag;
   logic [TAG_W-1:0]   tag_out;

   // Body count clamp and pair-walk boundary decode
   always_comb begin
      n_clamp_c = (num_bodies > (AW+1)'(BODIES)) ? (AW+1)'(BODIES) : num_bodies;
      n_m1_c    = AW'(n_q - (AW+1)'(1));
`ifdef NBODY_PAIR_SKIP_SELF_EN
      pair_zero_c = (n_clamp_c <= (AW+1)'(1));
      first_j_c   = AW'(1);
      row_last_c  = (rd_j == n_m1_c) ||
                    ((rd_i == n_m1_c) && (rd_j == AW'(n_q - (AW+1)'(2))));
      self_c      = 1'b0;
`else
      pair_zero_c = (n_clamp_c == '0);
      first_j_c   = '0;
      row_last_c  = (rd_j == n_m1_c);
      self_c      = (rd_i == rd_j);
`endif
      last_c = row_last_c && (rd_i == n_m1_c);
   end

   // Tag for the pair currently on the read address ports
   always_comb begin
      tag_in_c        = '0;
      tag_in_c.valid  = issue_valid;
      tag_in_c.i      = rd_i;
      tag_in_c.j      = rd_j;
      tag_in_c.self   = self_c;
      tag_in_c.last_j = row_last_c;
      tag_in_c.last   = last_c;
   end

   // Sweep controller: IDLE -> ISSUE -> DRAIN -> FINISH, abort returns to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         n_q         <= '0;
         drain_cnt   <= '0;
         rd_i        <= '0;
         rd_j        <= '0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else if (abort) begin
         state       <= ST_IDLE;
         drain_cnt   <= '0;
         rd_i        <= '0;
         rd_j        <= '0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  n_q <= n_clamp_c;
                  if (pair_zero_c) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state       <= ST_ISSUE;
                     busy        <= 1'b1;
                     issue_valid <= 1'b1;
                     rd_i        <= '0;
                     rd_j        <= first_j_c;
                  end
               end
            end
            ST_ISSUE: begin
               if (last_c) begin
                  state       <= ST_DRAIN;
                  issue_valid <= 1'b0;
                  drain_cnt   <= '0;
               end else if (row_last_c) begin
                  rd_i <= AW'(rd_i + AW'(1));
                  rd_j <= '0;
               end else begin
`ifdef NBODY_PAIR_SKIP_SELF_EN
                  if (AW'(rd_j + AW'(1)) == rd_i) rd_j <= AW'(rd_j + AW'(2));
                  else                            rd_j <= AW'(rd_j + AW'(1));
`else
                  rd_j <= AW'(rd_j + AW'(1));
`endif
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_W'(TAG_DELAY - 1)) begin
                  state <= ST_FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  rd_i  <= '0;
                  rd_j  <= '0;
               end else begin
                  drain_cnt <= DRAIN_W'(drain_cnt + DRAIN_W'(1));
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tag_delay_line #(
      .DEPTH (TAG_DELAY),
      .WIDTH (TAG_W)
   ) u_tag_delay (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .din   (tag_in_c),
      .dout  (tag_out)
   );

   assign res_tag    = pair_tag_t'(tag_out);
   assign res_valid  = res_tag.valid;
   assign res_i      = res_tag.i;
   assign res_j      = res_tag.j;
   assign res_self   = res_tag.self;
   assign res_last_j = res_tag.last_j;
   assign res_last   = res_tag.last;

endmodule

// File: tb/tb_nbody_pair_sequencer.sv
// Self-checking bench for nbody_pair_sequencer: cycle-by-cycle comparison against an index-arithmetic model.
module tb_nbody_pair_sequencer;
   import nbody_pkg::*;

   localparam int AW = BODY_ADDR_WIDTH;
   localparam int D  = RAM_LATENCY + ACCL_LATENCY;
`ifdef NBODY_PAIR_SKIP_SELF_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [AW:0]   num_bodies;
   logic [AW-1:0] rd_i, rd_j, res_i, res_j;
   logic          issue_valid, res_valid, res_self, res_last_j, res_last, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   nbody_pair_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .num_bodies  (num_bodies),
      .rd_i        (rd_i),
      .rd_j        (rd_j),
      .issue_valid (issue_valid),
      .res_valid   (res_valid),
      .res_i       (res_i),
      .res_j       (res_j),
      .res_self    (res_self),
      .res_last_j  (res_last_j),
      .res_last    (res_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int npairs(input int n);
      if (SKIP) return (n <= 1) ? 0 : n * (n - 1);
      return n * n;
   endfunction

   // Pair k of a sweep over n bodies, i-major, optionally skipping the diagonal
   function automatic void pair_of(input int n, input int k, output int pi, output int pj,
                                   output bit ps, output bit plj);
      int r;
      if (SKIP) begin
         pi  = k / (n - 1);
         r   = k % (n - 1);
         pj  = (r < pi) ? r : r + 1;
         plj = (r == n - 2);
      end else begin
         pi  = k / n;
         pj  = k % n;
         plj = (pj == n - 1);
      end
      ps = (pi == pj);
   endfunction

   function automatic logic [63:0] pack(input bit b, input bit d, input bit iv, input int ri, input int rj,
                                        input bit rv, input int si, input int sj,
                                        input bit ss, input bit slj, input bit sl);
      logic [63:0] v;
      v = '0;
      v[42]    = b;
      v[41]    = d;
      v[40]    = iv;
      v[39:31] = 9'(ri);
      v[30:22] = 9'(rj);
      v[21]    = rv;
      if (rv) begin
         v[20:12] = 9'(si);
         v[11:3]  = 9'(sj);
         v[2]     = ss;
         v[1]     = slj;
         v[0]     = sl;
      end
      return v;
   endfunction

   // One sweep: start at cycle 0, optional abort / ignored restart / num_bodies change
   task automatic run_sweep(input int n_req, input int abort_cyc, input int restart_cyc,
                            input int nb_cyc, input int nb_val);
      int n, p, lim, alim, res_cnt, exp_res;
      int pi, pj, k;
      bit ps, plj;
      bit e_b, e_d, e_iv, e_rv, e_ss, e_slj, e_sl;
      int e_ri, e_rj, e_si, e_sj;
      logic [63:0] obs, exp;
      string tag;

      n       = (n_req > int'(BODIES)) ? int'(BODIES) : n_req;
      p       = npairs(n);
      alim    = (abort_cyc > 0) ? abort_cyc : 32'h7fff_ffff;
      lim     = (abort_cyc > 0) ? abort_cyc + D + 5 : p + D + 3;
      res_cnt = 0;
      exp_res = 0;

      num_bodies = (AW+1)'(n_req);
      start      = 1'b1;
      abort      = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= lim; c++) begin
         @(negedge clk);
         e_b = 0; e_d = 0; e_iv = 0; e_rv = 0; e_ss = 0; e_slj = 0; e_sl = 0;
         e_ri = 0; e_rj = 0; e_si = 0; e_sj = 0;
         if (c <= alim) begin
            e_b = (p > 0) && (c <= p + D);
            e_d = (p > 0) ? (c == p + D + 1) : (c == 1);
            if (c <= p) begin
               pair_of(n, c - 1, e_ri, e_rj, ps, plj);
               e_iv = 1;
            end else if (p > 0 && c <= p + D) begin
               pair_of(n, p - 1, e_ri, e_rj, ps, plj);
            end
            k = c - 1 - D;
            if (k >= 0 && k < p) begin
               pair_of(n, k, pi, pj, ps, plj);
               e_rv = 1; e_si = pi; e_sj = pj; e_ss = ps; e_slj = plj; e_sl = (k == p - 1);
               exp_res++;
            end
         end
         exp = pack(e_b, e_d, e_iv, e_ri, e_rj, e_rv, e_si, e_sj, e_ss, e_slj, e_sl);
         obs = pack(busy, done, issue_valid, int'(rd_i), int'(rd_j), res_valid, int'(res_i),
                    int'(res_j), res_self, res_last_j, res_last);
         if (res_valid) res_cnt++;
         tag = $sformatf("n%0d_c%0d", n_req, c);
         check_eq(tag, obs, exp);
         start = (c == restart_cyc);
         abort = (c == abort_cyc);
         if (c == nb_cyc) num_bodies = (AW+1)'(nb_val);
      end
      start = 1'b0;
      abort = 1'b0;
      check_eq($sformatf("nres_n%0d", n_req), 64'(res_cnt), 64'(exp_res));
   endtask

   initial begin
      int n, a;
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      num_bodies = '0;
      repeat (3) @(negedge clk);
      check_eq("reset", pack(busy, done, issue_valid, int'(rd_i), int'(rd_j), res_valid, int'(res_i),
                             int'(res_j), res_self, res_last_j, res_last), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_sweep(3, 0, 0, 0, 0);
      run_sweep(0, 0, 0, 0, 0);
      run_sweep(1, 0, 0, 0, 0);
      run_sweep(4, 5, 0, 0, 0);
      run_sweep(4, 0, 0, 0, 0);
      run_sweep(2, 0, 3, 2, 5);
      run_sweep(600, 600, 0, 0, 0);
      run_sweep(3, 0, 0, 0, 0);

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(0, 9);
         a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, npairs(n) + D + 1) : 0;
         run_sweep(n, a, 0, 0, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
